// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store port between execute stage and a simple memory bus.
module lsu_mem_port #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [XLEN-1:0]     rsp_data,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic [1:0]          rsp_err
);
  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  typedef enum logic [1:0] {IDLE, BUS, WAIT, RESP} state_t;
  state_t state;
  logic [1:0] size_q;
  logic uns_q;
  logic [OFF_W-1:0] off_q;
  logic [15:0] cnt;
  logic [2:0] amask;
  logic bad;
  logic [OFF_W-1:0] off;
  logic [7:0] lanes;
  logic [BE_W-1:0] be;
  logic [XLEN-1:0] rsh, mask, ld;
  logic [6:0] nbits;
  logic tmo;
  assign req_ready = state == IDLE;
  always_comb begin
    amask = req_size == 2'd0 ? 3'd0 : req_size == 2'd1 ? 3'd1 : req_size == 2'd2 ? 3'd3 : 3'd7;
    bad   = |(req_addr[2:0] & amask) || (XLEN == 32 && req_size == 2'd3);
    off   = req_addr[OFF_W-1:0];
    lanes = req_size == 2'd0 ? 8'h01 : req_size == 2'd1 ? 8'h03 : req_size == 2'd2 ? 8'h0F : 8'hFF;
    be    = BE_W'(lanes) << off;
    // Load extraction: the top bit of the size mask selects the sign bit.
    rsh   = mem_rdata >> {off_q, 3'b000};
    nbits = 7'd8 << size_q;
    mask  = {XLEN{1'b1}} >> (7'(XLEN) - nbits);
    ld    = (rsh & mask) | ((!uns_q && |(rsh & (mask ^ (mask >> 1)))) ? ~mask : '0);
    tmo   = cnt == 16'(TIMEOUT - 1);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      size_q    <= '0;
      uns_q     <= 1'b0;
      off_q     <= '0;
      cnt       <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          size_q  <= req_size;
          uns_q   <= req_unsigned;
          off_q   <= off;
          rsp_tag <= req_tag;
          cnt     <= '0;
          if (bad) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'b01;
            rsp_data  <= '0;
          end else begin
            state     <= BUS;
            mem_valid <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_be    <= be;
            mem_wdata <= req_wdata << {off, 3'b000};
          end
        end
        BUS: begin
          cnt <= cnt + 16'd1;
          if (mem_ready || tmo) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rsp_data  <= '0;
            rsp_err   <= mem_ready ? 2'b00 : 2'b10;
            state     <= (mem_ready && !mem_we) ? WAIT : RESP;
            rsp_valid <= !(mem_ready && !mem_we);
          end
        end
        WAIT: begin
          cnt <= cnt + 16'd1;
          if (mem_rvalid || tmo) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= mem_rvalid ? ld : '0;
            rsp_err   <= mem_rvalid ? 2'b00 : 2'b10;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed and random load/store traffic against a byte-level reference model.
module tb_lsu_mem_port;
  logic clock = 1'b0;
  logic reset;
  logic req_valid, req_ready, req_we, req_unsigned;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0] req_tag;
  logic mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  logic rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0] rsp_tag;
  logic [1:0] rsp_err;
  int total = 0;
  int bad = 0;
  logic [31:0] got;

  lsu_mem_port #(.XLEN(32), .ADDR_W(32), .TAG_W(5), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] rd, input int off, input int n, input bit uns);
    longint v;
    v = longint'(rd >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
    if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_be(input int off, input int n);
    int b = 0;
    for (int i = 0; i < n; i++) b += 1 << (off + i);
    return 4'(b);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] rd, input logic [4:0] tg,
                    input int bd, input int rvd, input int hold, output logic [31:0] res);
    int n, off;
    bit mis;
    logic [31:0] exp_data, exp_wd;
    n = 1 << sz;
    off = int'(a % 4);
    mis = (a % n) != 0 || n > 4;
    exp_wd = wd << (8 * off);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; req_tag = tg;
    tick();
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_tag = 5'($urandom);
    if (mis) chk("mis_no_bus", mem_valid, 0);
    else begin
      for (int i = 0; i <= bd; i++) begin
        chk("mem_valid", mem_valid, 1);
        chk("mem_addr", mem_addr, a - 32'(off));
        chk("mem_be", mem_be, m_be(off, n));
        chk("mem_we", mem_we, we);
        chk("mem_wdata", mem_wdata, exp_wd);
        mem_ready = (i == bd);
        tick();
      end
      mem_ready = 0;
      chk("mem_valid_off", mem_valid, 0);
      chk("mem_be_off", mem_be, 0);
      if (!we) begin
        for (int i = 0; i <= rvd; i++) begin
          chk("no_early_rsp", rsp_valid, 0);
          mem_rvalid = (i == rvd);
          mem_rdata = (i == rvd) ? rd : $urandom;
          tick();
        end
        mem_rvalid = 0;
        mem_rdata = $urandom;
      end
    end
    exp_data = (mis || we) ? 32'h0 : m_load(rd, off, n, uns);
    res = rsp_data;
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_err", rsp_err, mis ? 2'b01 : 2'b00);
      chk("rsp_tag", rsp_tag, tg);
      chk("req_ready_busy", req_ready, 0);
      rsp_ready = (i == hold);
      tick();
    end
    rsp_ready = 0;
    chk("rsp_valid_off", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  initial begin
    int k, bd;
    logic [1:0] sz;
    reset = 1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; req_tag = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; rsp_ready = 0;
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    @(posedge clock);
    #1 reset = 0;

    op(0, 2'd0, 0, 32'h1003, 32'h0, 32'h80FF0000, 5'd3, 0, 0, 0, got);
    chk("lb_signed", got, 32'hFFFFFF80);
    op(0, 2'd0, 1, 32'h1003, 32'h0, 32'h80FF0000, 5'd4, 0, 0, 0, got);
    chk("lb_unsigned", got, 32'h00000080);
    op(1, 2'd1, 0, 32'h2002, 32'h1234ABCD, 32'h0, 5'd5, 0, 0, 0, got);
    chk("sh_data_zero", got, 32'h0);
    op(0, 2'd2, 0, 32'h1002, 32'h0, 32'h0, 5'd6, 0, 0, 0, got);
    op(0, 2'd3, 0, 32'h1000, 32'h0, 32'h0, 5'd7, 0, 0, 0, got);
    op(0, 2'd1, 0, 32'h1002, 32'h0, 32'h8001CAFE, 5'd8, 1, 0, 3, got);
    op(0, 2'd2, 1, 32'h1004, 32'h0, 32'hDEADBEEF, 5'd9, 0, 1, 3, got);

    // Stray read data while idle must not produce a response.
    mem_rvalid = 1; mem_rdata = 32'h12345678;
    tick();
    mem_rvalid = 0;
    chk("stray_rvalid", rsp_valid, 0);
    chk("stray_ready", req_ready, 1);

    req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h3000; req_tag = 5'd10;
    tick();
    req_valid = 0;
    k = 0;
    while (mem_valid && k < 10) begin
      k++;
      tick();
    end
    chk("tmo_cycles", k, 4);
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_err", rsp_err, 2'b10);
    chk("tmo_data", rsp_data, 0);
    chk("tmo_mem_valid", mem_valid, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("tmo_back_idle", req_ready, 1);

    req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h4000; req_tag = 5'd17;
    tick();
    req_valid = 0; mem_ready = 1;
    tick();
    mem_ready = 0;
    chk("pre_rst_wait", mem_valid, 0);
    #2 reset = 1;
    #1;
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_tag", rsp_tag, 0);
    chk("midrst_mem_be", mem_be, 0);
    @(posedge clock);
    #1 reset = 0;
    mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_rvalid = 0;
    tick();
    chk("late_rvalid_rsp", rsp_valid, 0);
    chk("late_rvalid_ready", req_ready, 1);
    chk("late_rvalid_data", rsp_data, 0);

    for (int t = 0; t < 60; t++) begin
      sz = 2'($urandom_range(0, 3));
      bd = $urandom_range(0, 1);
      op(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
         bd, bd ? 0 : $urandom_range(0, 1), $urandom_range(0, 2), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
